// File: rtl/aes_round_sched.sv
// AES-128 round scheduler: owns the cipher state and sequences the key-expansion
// and per-round stage wrappers through one-cycle enables and finished handshakes.
module aes_round_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  output logic [127:0] state_out,
  output logic         sub_enable,
  output logic         shift_enable,
  output logic         mix_enable,
  output logic         around_enable,
  input  logic         sub_finished,
  input  logic         shift_finished,
  input  logic         mix_finished,
  input  logic         around_finished,
  input  logic [127:0] sub_data,
  input  logic [127:0] shift_data,
  input  logic [127:0] mix_data,
  input  logic [127:0] around_data,
  output logic         key_req,
  output logic [3:0]   key_round,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic [127:0] subkey_out,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    IDLE, KEY, ARK, SUB, SHIFT, MIX, DONE, ERR
  } state_t;

  state_t       state;
  logic         issued;
  logic [7:0]   watchdog;
  logic         fin;
  logic [127:0] fin_data;

  // Only the responder belonging to the current state is listened to.
  always_comb begin
    fin      = 1'b0;
    fin_data = '0;
    case (state)
      KEY:     begin fin = key_valid;       fin_data = key_in;      end
      ARK:     begin fin = around_finished; fin_data = around_data; end
      SUB:     begin fin = sub_finished;    fin_data = sub_data;    end
      SHIFT:   begin fin = shift_finished;  fin_data = shift_data;  end
      MIX:     begin fin = mix_finished;    fin_data = mix_data;    end
      default: begin fin = 1'b0;            fin_data = '0;          end
    endcase
  end

  assign busy      = (state != IDLE) && (state != DONE) && (state != ERR);
  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign key_round = round;

  // Enables are set on the edge that enters a handshake state, so each one is
  // high for exactly the issue cycle and dropped by the default below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      issued        <= 1'b0;
      watchdog      <= '0;
      state_out     <= '0;
      subkey_out    <= '0;
      round         <= '0;
      sub_enable    <= 1'b0;
      shift_enable  <= 1'b0;
      mix_enable    <= 1'b0;
      around_enable <= 1'b0;
      key_req       <= 1'b0;
    end else begin
      sub_enable    <= 1'b0;
      shift_enable  <= 1'b0;
      mix_enable    <= 1'b0;
      around_enable <= 1'b0;
      key_req       <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_out <= plaintext;
            round     <= '0;
            issued    <= 1'b0;
            key_req   <= 1'b1;
            state     <= KEY;
          end
        end
        default: begin
          if (!issued) begin
            issued   <= 1'b1;
            watchdog <= '0;
          end else if (fin) begin
            issued <= 1'b0;
            if (state == KEY) subkey_out <= fin_data;
            else              state_out  <= fin_data;
            case (state)
              KEY: begin
                around_enable <= 1'b1;
                state         <= ARK;
              end
              ARK: begin
                if (round == 4'd10) begin
                  state <= DONE;
                end else begin
                  round      <= round + 4'd1;
                  sub_enable <= 1'b1;
                  state      <= SUB;
                end
              end
              SUB: begin
                shift_enable <= 1'b1;
                state        <= SHIFT;
              end
              SHIFT: begin
                // The final round skips mix-columns.
                if (round == 4'd10) begin
                  key_req <= 1'b1;
                  state   <= KEY;
                end else begin
                  mix_enable <= 1'b1;
                  state      <= MIX;
                end
              end
              MIX: begin
                key_req <= 1'b1;
                state   <= KEY;
              end
              default: state <= ERR;
            endcase
          end else if (watchdog == 8'(TIMEOUT - 1)) begin
            state  <= ERR;
            issued <= 1'b0;
          end else begin
            watchdog <= watchdog + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/aes_round_sched.md
# aes_round_sched

Round scheduler for the AES-128 encryption datapath. It holds the 128-bit cipher state and sequences the per-round stage wrappers (sub-bytes, shift-rows, mix-columns, add-round-key) and the key-expansion unit through enable/finished handshakes. It runs one initial key addition, nine full rounds and one final round without mix-columns. It sits between the top-level host interface and the stage wrappers, and is the only block that drives their enables.

## Interface
- TIMEOUT, 64: maximum cycles to wait for any finished/valid before aborting (1..255)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin encryption of plaintext; honoured only in IDLE, DONE or ERR
- plaintext  in  128  input block, sampled on the accepted start edge
- state_out  out  128  current cipher state, driven to every stage's olddata input
- sub_enable / shift_enable / mix_enable / around_enable  out  1 each  one-cycle stage start pulses
- sub_finished / shift_finished / mix_finished / around_finished  in  1 each  stage completion
- sub_data / shift_data / mix_data / around_data  in  128 each  stage results, valid with finished
- key_req  out  1  one-cycle request for the round key of key_round
- key_round  out  4  round index 0..10 for the key request
- key_valid  in  1  key-expansion completion
- key_in  in  128  round key, valid with key_valid
- subkey_out  out  128  latched round key, driven to add-round-key
- round  out  4  current round 0..10
- busy  out  1  high in every state except IDLE, DONE, ERR
- done  out  1  high while in DONE (state_out is the ciphertext)
- error  out  1  high while in ERR

## Operation
- States: IDLE, KEY, ARK, SUB, SHIFT, MIX, DONE, ERR. Each handshake state has an issue phase and a wait phase, tracked by an internal issued flag.
- Issue phase is the first cycle in the state. Pulse the state's enable (key_req for KEY) and clear the watchdog.
- Wait phase: finished/valid is ignored in the issue cycle and sampled from the next cycle on.
  - On finished/valid: capture the data (stage data into state_out; key_in into subkey_out) and advance.
  - Otherwise the watchdog increments. If it reaches TIMEOUT, go to ERR with no capture.
- Accepted start: load plaintext into state_out, round=0, go to KEY.
- Order for round 0: KEY, ARK.
- Order for rounds 1..9: SUB, SHIFT, MIX, KEY, ARK.
- Order for round 10: SUB, SHIFT, KEY, ARK.
- round increments on leaving ARK when round<10. ARK with round==10 goes to DONE.
- key_round equals round.
- DONE and ERR hold all registers until the next start. A start from DONE or ERR behaves as from IDLE and clears error.
- start while busy is ignored and has no effect on the sequence.
- Simultaneous finished on a stage that is not currently being waited on is ignored.

## Timing
- Reset values:
  - state IDLE
  - state_out, subkey_out all zero
  - round 0, key_round 0
  - all enables, key_req, busy, done, error 0
- Reset mid-operation aborts immediately to these values. Stages see no further enables.
- Per handshake: 1 issue cycle plus N wait cycles, where finished arrives N≥1 cycles after the enable. Capture and advance happen on the same edge that samples finished.
- Total handshakes: 51 (11 key, 11 ARK, 10 SUB, 10 SHIFT, 9 MIX).
- With every responder at N=1, start sampled at edge E gives done=1 in the cycle after edge E+102.
- done, busy and error are registered state decodes, not pulses.

## Test plan
- Reset mid-run: assert rst at round 5 MIX -> all outputs return to reset values, no enable pulses follow, and a new start completes normally.
- Functional run: FIPS-197 vector, plaintext 00112233445566778899aabbccddeeff, responders from the golden stage models with N=1 -> state_out=69c4e0d86a7b0430d8cdb78070b4c55a, done in the cycle after edge E+102, exactly 9 mix_enable pulses.
- Sequence check: scoreboard the enable order -> KEY0, ARK, then (SUB, SHIFT, MIX, KEY, ARK)×9, then SUB, SHIFT, KEY10, ARK. key_round matches round on each key_req.
- Variable latency: N random 1..20 per handshake -> same ciphertext, done once, busy high throughout.
- Watchdog: TIMEOUT=8, shift_finished never asserted in round 3 -> ERR exactly 8 cycles after the wait phase begins, error=1, busy=0, state_out unchanged. A subsequent start runs to DONE with error=0.
- Ignored inputs:
  - start pulsed during round 4 -> no restart and an identical result.
  - finished asserted in the issue cycle only -> not captured, and the watchdog fires.
